vec_mult_arbiter: RTL
=====================

// Module: vec_mult_arbiter
// PURPOSE
// Shares one vector_mult datapath (N lanes x bitwidth, fixed-latency, no backpressure) between two
// packet-stream requesters. Packet-level round-robin arbitration on the issue side; a tag FIFO
// (one tag per issued beat) routes each result beat back to its owner. Sits between two
// compute/load engines and the shared vector_mult instance.
// PARAMETERS
// bitwidth   16  width of one lane element
// N          8   lanes per beat
// TAG_DEPTH  16  tag FIFO entries (power of 2); must be >= multiplier latency+2 for full throughput
// PORTS
// clk          in   1           clock
// rstn         in   1           asynchronous active-low reset
// s0_in0       in   N*bitwidth  requester 0 operand A
// s0_in1       in   N*bitwidth  requester 0 operand B
// s0_valid     in   1           requester 0 beat valid
// s0_last      in   1           requester 0 last beat of packet
// s0_ready     out  1           requester 0 beat accepted when valid&ready
// s1_in0/s1_in1/s1_valid/s1_last/s1_ready   same as s0_*, requester 1
// m_in0        out  N*bitwidth  to vector_mult in0 (registered)
// m_in1        out  N*bitwidth  to vector_mult in1 (registered)
// m_valid      out  1           to vector_mult in_valid
// m_last       out  1           to vector_mult in_last
// m_out        in   N*bitwidth  from vector_mult out
// m_out_valid  in   1           from vector_mult out_valid
// m_out_last   in   1           from vector_mult out_last
// r0_data      out  N*bitwidth  result to requester 0 (registered)
// r0_valid     out  1           result beat valid, requester 0 (no backpressure; always accepted)
// r0_last      out  1           last result beat of packet, requester 0
// r1_data/r1_valid/r1_last      same as r0_*, requester 1
// busy         out  1           state!=IDLE or tag FIFO non-empty
// err_orphan   out  1           sticky: result beat arrived with empty tag FIFO
// BEHAVIOUR
// - Reset (rstn=0, async): FSM=IDLE, last_served=1, tag FIFO empty, all outputs 0 (data included).
// - FSM IDLE -> GRANT0/GRANT1 -> IDLE. In IDLE: only s0_valid -> GRANT0; only s1_valid -> GRANT1;
//   both -> grant requester != last_served; neither -> stay. Decision takes 1 cycle; ready=0 in IDLE.
// - In GRANTk: sk_ready = !tag_full; other requester's ready=0. Accepted beat (valid&ready):
//   next cycle m_valid=1, m_in0/m_in1/m_last = captured beat; tag k pushed same cycle as accept.
//   No accept -> next cycle m_valid=0, m_last=0, m_in* hold last value.
// - Accepted beat with last=1: last_served<=k, FSM->IDLE next cycle (1 bubble cycle per packet).
//   Grant is held across idle gaps inside a packet (valid=0 mid-packet keeps GRANTk).
// - Tag FIFO: push on accept, pop on m_out_valid. ready uses full only; a pop in the full cycle
//   frees space from the next cycle. Push+pop same cycle: count unchanged.
// - Result routing: on m_out_valid with non-empty FIFO, head tag h: next cycle rh_valid=1,
//   rh_data=m_out, rh_last=m_out_last; other r*_valid=0. Result latency = multiplier latency + 2
//   cycles from accept. r*_data holds when valid=0.
// - m_out_valid with FIFO empty: beat dropped, no r*_valid, err_orphan<=1 until reset.
// - Per-requester result order equals issue order; packets of 0 and 1 never interleave on output
//   at beat granularity beyond issue order.
// - Reset mid-operation: all state and in-flight tags discarded; vector_mult shares rstn, so its
//   pipeline is flushed too; no orphan is flagged for pre-reset beats.
// TESTING
// 1 Only s0: 3-beat packet, lane i A=i, B=2.0 (fp16) -> m_valid 3 cycles starting 2 cycles after
//   s0_valid; r0 gets 3 beats A*2, r0_last on 3rd; r1_valid never 1.
// 2 s0,s1 valid same cycle from reset -> s0 packet issued first (last_served=1), then s1 after
//   1 IDLE cycle; repeat -> s0 again; results routed to correct r*_.
// 3 Model multiplier latency 20 with TAG_DEPTH=16 -> sk_ready drops after 16 accepts in flight,
//   resumes the cycle after first pop; no beat lost or duplicated over 100-beat packet.
// 4 Inject m_out_valid=1 with nothing issued -> err_orphan=1 next cycle, stays 1; r*_valid=0.
// 5 Assert rstn=0 mid-packet (beat 2 of 4) -> all outputs 0 immediately, busy=0, FSM IDLE after
//   release; new packet from s1 completes normally.
// 6 s0 drops valid for 5 cycles mid-packet while s1 valid -> s1_ready stays 0 until s0_last accepted.

Source files
------------

// File: rtl/vec_mult_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared vector_mult.
// slave: arbiter view. master: environment view (requesters + multiplier).
interface vec_mult_arbiter_if #(
  parameter int unsigned bitwidth = 16,
  parameter int unsigned N        = 8
);
  localparam int unsigned W = N * bitwidth;

  logic [W-1:0] s0_in0, s0_in1;
  logic         s0_valid, s0_last, s0_ready;
  logic [W-1:0] s1_in0, s1_in1;
  logic         s1_valid, s1_last, s1_ready;
  logic [W-1:0] m_in0, m_in1;
  logic         m_valid, m_last;
  logic [W-1:0] m_out;
  logic         m_out_valid, m_out_last;
  logic [W-1:0] r0_data;
  logic         r0_valid, r0_last;
  logic [W-1:0] r1_data;
  logic         r1_valid, r1_last;

  modport slave (
    input  s0_in0, s0_in1, s0_valid, s0_last,
    output s0_ready,
    input  s1_in0, s1_in1, s1_valid, s1_last,
    output s1_ready,
    output m_in0, m_in1, m_valid, m_last,
    input  m_out, m_out_valid, m_out_last,
    output r0_data, r0_valid, r0_last,
    output r1_data, r1_valid, r1_last
  );

  modport master (
    output s0_in0, s0_in1, s0_valid, s0_last,
    input  s0_ready,
    output s1_in0, s1_in1, s1_valid, s1_last,
    input  s1_ready,
    input  m_in0, m_in1, m_valid, m_last,
    output m_out, m_out_valid, m_out_last,
    input  r0_data, r0_valid, r0_last,
    input  r1_data, r1_valid, r1_last
  );
endinterface

// File: rtl/vec_mult_arbiter.sv
// Packet-level round-robin arbiter sharing one fixed-latency vector_mult
// between two requesters. A tag FIFO (one entry per issued beat) steers each
// returning result beat to the requester that issued it.
module vec_mult_arbiter #(
  parameter int unsigned bitwidth  = 16,
  parameter int unsigned N         = 8,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  vec_mult_arbiter_if.slave bus,
  output logic              busy,
  output logic              err_orphan
);
  localparam int unsigned W  = N * bitwidth;
  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state_q, state_d;
  logic          last_served_q, last_served_d;
  logic          tag_mem_q [TAG_DEPTH];
  logic          tag_mem_d [TAG_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [W-1:0]  m_in0_q, m_in0_d, m_in1_q, m_in1_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [W-1:0]  r0_data_q, r0_data_d, r1_data_q, r1_data_d;
  logic          r0_valid_q, r0_valid_d, r0_last_q, r0_last_d;
  logic          r1_valid_q, r1_valid_d, r1_last_q, r1_last_d;
  logic          err_q, err_d;

  logic tag_full, tag_empty, acc0, acc1, push, pop, head;

  // Handshake qualifiers; ready looks at full only so a same-cycle pop never widens it
  always_comb begin
    tag_full  = (count_q == FULL_CNT);
    tag_empty = (count_q == '0);
    acc0      = (state_q == GRANT0) && bus.s0_valid && !tag_full;
    acc1      = (state_q == GRANT1) && bus.s1_valid && !tag_full;
    push      = acc0 || acc1;
    pop       = bus.m_out_valid && !tag_empty;
    head      = tag_mem_q[rd_ptr_q];
  end

  // Arbitration FSM: grant held for a whole packet, round-robin between packets
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    unique case (state_q)
      IDLE: begin
        if (bus.s0_valid && (!bus.s1_valid || last_served_q)) state_d = GRANT0;
        else if (bus.s1_valid)                                state_d = GRANT1;
      end
      GRANT0: if (acc0 && bus.s0_last) begin
        state_d       = IDLE;
        last_served_d = 1'b0;
      end
      GRANT1: if (acc1 && bus.s1_last) begin
        state_d       = IDLE;
        last_served_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue register towards the multiplier plus tag FIFO bookkeeping
  always_comb begin
    m_valid_d = push;
    m_last_d  = (acc0 && bus.s0_last) || (acc1 && bus.s1_last);
    m_in0_d   = m_in0_q;
    m_in1_d   = m_in1_q;
    if (acc0) begin
      m_in0_d = bus.s0_in0;
      m_in1_d = bus.s0_in1;
    end else if (acc1) begin
      m_in0_d = bus.s1_in0;
      m_in1_d = bus.s1_in1;
    end

    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = acc1;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);
  end

  // Result steering by FIFO head tag; orphan beats are dropped and flagged
  always_comb begin
    r0_valid_d = pop && !head;
    r1_valid_d = pop && head;
    r0_last_d  = r0_valid_d && bus.m_out_last;
    r1_last_d  = r1_valid_d && bus.m_out_last;
    r0_data_d  = r0_valid_d ? bus.m_out : r0_data_q;
    r1_data_d  = r1_valid_d ? bus.m_out : r1_data_q;
    err_d      = err_q || (bus.m_out_valid && tag_empty);
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      m_in0_q       <= '0;
      m_in1_q       <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      r0_data_q     <= '0;
      r0_valid_q    <= 1'b0;
      r0_last_q     <= 1'b0;
      r1_data_q     <= '0;
      r1_valid_q    <= 1'b0;
      r1_last_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      tag_mem_q     <= tag_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      m_in0_q       <= m_in0_d;
      m_in1_q       <= m_in1_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      r0_data_q     <= r0_data_d;
      r0_valid_q    <= r0_valid_d;
      r0_last_q     <= r0_last_d;
      r1_data_q     <= r1_data_d;
      r1_valid_q    <= r1_valid_d;
      r1_last_q     <= r1_last_d;
      err_q         <= err_d;
    end
  end

  // Output mapping
  always_comb begin
    bus.s0_ready = (state_q == GRANT0) && !tag_full;
    bus.s1_ready = (state_q == GRANT1) && !tag_full;
    bus.m_in0    = m_in0_q;
    bus.m_in1    = m_in1_q;
    bus.m_valid  = m_valid_q;
    bus.m_last   = m_last_q;
    bus.r0_data  = r0_data_q;
    bus.r0_valid = r0_valid_q;
    bus.r0_last  = r0_last_q;
    bus.r1_data  = r1_data_q;
    bus.r1_valid = r1_valid_q;
    bus.r1_last  = r1_last_q;
    busy         = (state_q != IDLE) || !tag_empty;
    err_orphan   = err_q;
  end
endmodule
